// File: rtl/controlador_semaforos_pkg.sv
// Shared types and defaults for the two-way traffic-light controller:
// phase encoding, light bundle, phase sequencing and light decode helpers.
package controlador_semaforos_pkg;

  localparam int T_MIN          = 1;
  localparam int T_MAX          = 15;
  localparam int T_VERDE_DEF    = 9;
  localparam int T_AMARILLO_DEF = 3;
  localparam int T_ROJO_DEF     = 1;
  localparam int T_CORTO_DEF    = 3;

  typedef enum logic [2:0] {
    A_VERDE    = 3'd0,
    A_AMARILLO = 3'd1,
    ROJO_1     = 3'd2,
    B_VERDE    = 3'd3,
    B_AMARILLO = 3'd4,
    ROJO_2     = 3'd5
  } estado_t;

  typedef struct packed {
    logic va;
    logic aa;
    logic ra;
    logic vb;
    logic ab;
    logic rb;
  } luces_t;

  function automatic estado_t siguiente(input estado_t s);
    // NOTE: a default arm on every case keeps combinational decode latch-free.
    case (s)
      A_VERDE:    siguiente = A_AMARILLO;
      A_AMARILLO: siguiente = ROJO_1;
      ROJO_1:     siguiente = B_VERDE;
      B_VERDE:    siguiente = B_AMARILLO;
      B_AMARILLO: siguiente = ROJO_2;
      default:    siguiente = A_VERDE;
    endcase
  endfunction

  function automatic luces_t luces_de(input estado_t s);
    case (s)
      A_VERDE:    luces_de = '{va: 1'b1, aa: 1'b0, ra: 1'b0, vb: 1'b0, ab: 1'b0, rb: 1'b1};
      A_AMARILLO: luces_de = '{va: 1'b0, aa: 1'b1, ra: 1'b0, vb: 1'b0, ab: 1'b0, rb: 1'b1};
      B_VERDE:    luces_de = '{va: 1'b0, aa: 1'b0, ra: 1'b1, vb: 1'b1, ab: 1'b0, rb: 1'b0};
      B_AMARILLO: luces_de = '{va: 1'b0, aa: 1'b0, ra: 1'b1, vb: 1'b0, ab: 1'b1, rb: 1'b0};
      default:    luces_de = '{va: 1'b0, aa: 1'b0, ra: 1'b1, vb: 1'b0, ab: 1'b0, rb: 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/controlador_semaforos_divisor_1hz.sv
// Free-running prescaler: counts 0..CLK_HZ-1 and emits a registered
// one-cycle tick on each wrap.
module divisor_1hz #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [W-1:0] r_cnt;
  logic         r_tick;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == W'(CLK_HZ - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/controlador_semaforos.sv
// Two-way traffic-light controller: phase FSM, seconds countdown for the
// display, and request buttons that shorten the opposing green.
module controlador_semaforos
  import controlador_semaforos_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int T_VERDE    = T_VERDE_DEF,
  parameter int T_AMARILLO = T_AMARILLO_DEF,
  parameter int T_ROJO     = T_ROJO_DEF,
  parameter int T_CORTO    = T_CORTO_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  output logic       VA,
  output logic       AA,
  output logic       RA,
  output logic       VB,
  output logic       AB,
  output logic       RB,
  output logic [3:0] Numero,
  output logic       tick_1s
);

  function automatic logic [3:0] duracion(input estado_t s);
    case (s)
      A_VERDE, B_VERDE:       duracion = 4'(T_VERDE);
      A_AMARILLO, B_AMARILLO: duracion = 4'(T_AMARILLO);
      default:                duracion = 4'(T_ROJO);
    endcase
  endfunction

  logic       w_tick;
  logic [1:0] r_sync_a, r_sync_b;
  logic       r_prev_a, r_prev_b;
  logic       w_rise_a, w_rise_b;
  logic       r_pend_a, r_pend_b;
  logic       w_req;
  logic       w_en_verde;
  estado_t    r_state;
  estado_t    w_sig;
  logic [3:0] r_seg;
  luces_t     r_luces;

  divisor_1hz #(.CLK_HZ(CLK_HZ)) u_divisor (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[0], btn_a};
      r_sync_b <= {r_sync_b[0], btn_b};
      r_prev_a <= r_sync_a[1];
      r_prev_b <= r_sync_b[1];
    end
  end

  assign w_rise_a   = r_sync_a[1] & ~r_prev_a;
  assign w_rise_b   = r_sync_b[1] & ~r_prev_b;
  assign w_en_verde = (r_state == A_VERDE) || (r_state == B_VERDE);
  assign w_sig      = siguiente(r_state);

  // A fresh edge acts in the same cycle it is seen, so it can pre-empt a tick.
  assign w_req = ((r_state == A_VERDE) && (r_pend_b || w_rise_b)) ||
                 ((r_state == B_VERDE) && (r_pend_a || w_rise_a));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= A_VERDE;
      r_seg    <= 4'(T_VERDE);
      r_luces  <= luces_de(A_VERDE);
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
    end else begin
      if (w_req) begin
        if (r_seg > 4'(T_CORTO)) r_seg <= 4'(T_CORTO);
      end else if (w_tick) begin
        if (r_seg > 4'd1) begin
          r_seg <= r_seg - 4'd1;
        end else begin
          r_state <= w_sig;
          r_seg   <= duracion(w_sig);
          r_luces <= luces_de(w_sig);
        end
      end
      // Either green settles both flags: the opposing one is consumed, the own one is moot.
      r_pend_a <= w_en_verde ? 1'b0 : (r_pend_a | w_rise_a);
      r_pend_b <= w_en_verde ? 1'b0 : (r_pend_b | w_rise_b);
    end
  end

  assign VA      = r_luces.va;
  assign AA      = r_luces.aa;
  assign RA      = r_luces.ra;
  assign VB      = r_luces.vb;
  assign AB      = r_luces.ab;
  assign RB      = r_luces.rb;
  assign Numero  = r_seg;
  assign tick_1s = w_tick;

endmodule

// File: tb/tb_controlador_semaforos.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized button traffic checked every cycle against a behavioural model.
module tb_controlador_semaforos;

  localparam int CLK_HZ     = 4;
  localparam int T_VERDE    = 9;
  localparam int T_AMARILLO = 3;
  localparam int T_ROJO     = 1;
  localparam int T_CORTO    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       VA, AA, RA, VB, AB, RB, tick_1s;
  logic [3:0] Numero;

  int n_chk = 0;
  int n_err = 0;

  controlador_semaforos #(
    .CLK_HZ(CLK_HZ), .T_VERDE(T_VERDE), .T_AMARILLO(T_AMARILLO),
    .T_ROJO(T_ROJO), .T_CORTO(T_CORTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b),
    .VA(VA), .AA(AA), .RA(RA), .VB(VB), .AB(AB), .RB(RB),
    .Numero(Numero), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase index 0..5 = A green, A yellow, clearance, B green, B yellow, clearance.
  typedef struct {
    int       phase;
    int       secs;
    int       n;      // clock edges since reset release
    bit       tick;
    bit       pend_a;
    bit       pend_b;
    bit [2:0] ha;     // ha[0] = most recent button sample
    bit [2:0] hb;
  } model_t;

  function automatic int dur(input int p);
    return (p % 3 == 0) ? T_VERDE : (p % 3 == 1) ? T_AMARILLO : T_ROJO;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0; r.secs = T_VERDE; r.n = 0; r.tick = 1'b0;
    r.pend_a = 1'b0; r.pend_b = 1'b0; r.ha = '0; r.hb = '0;
    return r;
  endfunction

  function automatic model_t step(input model_t s, input bit ba, input bit bb);
    model_t r = s;
    bit ra = s.ha[1] & ~s.ha[2];
    bit rb = s.hb[1] & ~s.hb[2];
    bit req = (s.phase == 0 && (s.pend_b || rb)) || (s.phase == 3 && (s.pend_a || ra));
    bit green = (s.phase == 0) || (s.phase == 3);
    if (req) begin
      if (s.secs > T_CORTO) r.secs = T_CORTO;
    end else if (s.tick) begin
      if (s.secs > 1) r.secs = s.secs - 1;
      else begin
        r.phase = (s.phase + 1) % 6;
        r.secs  = dur(r.phase);
      end
    end
    r.pend_a = green ? 1'b0 : (s.pend_a | ra);
    r.pend_b = green ? 1'b0 : (s.pend_b | rb);
    r.ha   = {s.ha[1:0], ba};
    r.hb   = {s.hb[1:0], bb};
    r.n    = s.n + 1;
    r.tick = (r.n % CLK_HZ) == 0;
    return r;
  endfunction

  model_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, btn_a, btn_b);
  end

  // Per-cycle comparison against the model plus invariant checks.
  always @(negedge clk) begin
    check("lights_a", {VA, AA, RA}, m.phase == 0 ? 3'b100 : m.phase == 1 ? 3'b010 : 3'b001);
    check("lights_b", {VB, AB, RB}, m.phase == 3 ? 3'b100 : m.phase == 4 ? 3'b010 : 3'b001);
    check("numero", Numero, m.secs);
    check("tick_1s", tick_1s, m.tick);
    check("onehot_a", $countones({VA, AA, RA}), 1);
    check("onehot_b", $countones({VB, AB, RB}), 1);
    check("conflict", (VA | AA) & (VB | AB), 0);
    check("numero_nonzero", Numero != 4'd0, 1);
  end

  task automatic wait_to(input int e);
    for (int i = 0; i < 1000 && m.n < e; i++) @(negedge clk);
    check("wait_to_reached", m.n, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [5:0] L_AV = 6'b100001, L_AA = 6'b010001,
                         L_RR = 6'b001001, L_BV = 6'b001100;

  int         exp_num [17] = '{8, 7, 6, 5, 4, 3, 2, 1, 3, 2, 1, 1, 9, 8, 7, 6, 5};
  logic [5:0] exp_lum [17] = '{L_AV, L_AV, L_AV, L_AV, L_AV, L_AV, L_AV, L_AV,
                               L_AA, L_AA, L_AA, L_RR, L_BV, L_BV, L_BV, L_BV, L_BV};

  initial begin
    do_reset();
    check("rst_lights", {VA, AA, RA, VB, AB, RB}, L_AV);
    check("rst_numero", Numero, 9);
    check("rst_tick", tick_1s, 0);

    // Free run, no buttons: tick every 4 clocks, countdown through the phases.
    for (int k = 1; k <= 17; k++) begin
      wait_to(4 * k);
      check("run_tick_hi", tick_1s, 1);
      wait_to(4 * k + 1);
      check("run_tick_lo", tick_1s, 0);
      check("run_numero", Numero, exp_num[k-1]);
      check("run_lights", {VA, AA, RA, VB, AB, RB}, exp_lum[k-1]);
    end

    // btn_b at Numero 7 cuts A green to 3, yellow 3 ticks later; then btn_a in yellow.
    do_reset();
    wait_to(9);
    check("cut_pre", Numero, 7);
    btn_b = 1'b1;
    wait_to(12);
    check("cut_b", Numero, 3);
    btn_b = 1'b0;
    wait_to(20);
    check("cut_still_green", {VA, AA, RA, VB, AB, RB}, L_AV);
    wait_to(21);
    check("cut_yellow", {VA, AA, RA, VB, AB, RB}, L_AA);
    btn_a = 1'b1;
    wait_to(23);
    btn_a = 1'b0;
    wait_to(37);
    check("pend_a_bgreen", {VA, AA, RA, VB, AB, RB}, L_BV);
    check("pend_a_bfirst", Numero, 9);
    wait_to(38);
    check("pend_a_cut", Numero, 3);

    // Asynchronous reset off the clock edge in B yellow.
    wait_to(54);
    check("pre_rst_lights", {VA, AA, RA, VB, AB, RB}, 6'b001010);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lights", {VA, AA, RA, VB, AB, RB}, L_AV);
    check("async_rst_numero", Numero, 9);
    @(negedge clk);
    rst_n = 1'b1;
    wait_to(3);
    check("post_rst_no_tick", tick_1s, 0);
    wait_to(4);
    check("post_rst_tick", tick_1s, 1);

    // Edge detected in the same cycle as a tick at Numero 8.
    wait_to(6);
    btn_b = 1'b1;
    wait_to(8);
    check("coinc_pre", Numero, 8);
    wait_to(9);
    check("coinc_cut", Numero, 3);
    btn_b = 1'b0;

    // Request at Numero 2 is consumed without changing phase timing.
    do_reset();
    wait_to(29);
    btn_b = 1'b1;
    wait_to(32);
    check("late_keep", Numero, 2);
    btn_b = 1'b0;
    wait_to(36);
    check("late_green", {VA, AA, RA, VB, AB, RB}, L_AV);
    check("late_num", Numero, 1);
    wait_to(37);
    check("late_yellow", {VA, AA, RA, VB, AB, RB}, L_AA);

    // Randomized button traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) btn_a = ~btn_a;
      if ($urandom_range(0, 15) == 0) btn_b = ~btn_b;
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
